// File: rtl/sm_muldiv_pkg.sv
// Shared operation codes and FSM state encoding for the sm_muldiv multiply/divide unit.
package sm_muldiv_pkg;

    localparam logic [2:0] MD_MULTU = 3'b000;
    localparam logic [2:0] MD_DIVU  = 3'b001;
    localparam logic [2:0] MD_MULT  = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Codes 0xx run through the iterative datapath; 1xx are register moves or no-ops.
    function automatic logic op_is_arith(input logic [2:0] op);
        return op[2] == 1'b0;
    endfunction

endpackage

// File: rtl/sm_muldiv_step.sv
// One iteration of the multiply/divide datapath: shift-add multiply step or restoring-divide step.
module sm_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opd,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        trial   = shifted - {1'b0, opd};
        nxt_hi  = sum[WIDTH:1];
        nxt_lo  = {sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            // acc_lo shifts the dividend out at the top and the quotient in at the bottom.
            if (!trial[WIDTH]) begin
                nxt_hi = trial[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = shifted[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/sm_muldiv.sv
// Iterative MULTU/DIVU/MTHI/MTLO unit with HI/LO registers; signed MULT/DIV when
// SM_MULDIV_SIGNED_EN is defined, otherwise MULT/DIV behave as MULTU/DIVU.
module sm_muldiv
    import sm_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opd;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             is_div;
    logic             go;
    logic             div_zero;
    logic             launch;

    assign go       = start && (state == ST_IDLE);
    assign div_zero = go && op_is_arith(op) && op[0] && (srcB == '0);
    assign launch   = go && op_is_arith(op) && !div_zero;
    assign busy     = (state != ST_IDLE);

`ifdef SM_MULDIV_SIGNED_EN
    logic neg_a;
    logic neg_b;

    assign mag_a = (op[1] && srcA[WIDTH-1]) ? -srcA : srcA;
    assign mag_b = (op[1] && srcB[WIDTH-1]) ? -srcB : srcB;

    // Remainder follows the dividend's sign; product and quotient follow the sign difference.
    always_comb begin
        res_hi = acc_hi;
        res_lo = acc_lo;
        if (is_div) begin
            if (neg_a ^ neg_b) res_lo = -acc_lo;
            if (neg_a)         res_hi = -acc_hi;
        end else if (neg_a ^ neg_b) begin
            {res_hi, res_lo} = -{acc_hi, acc_lo};
        end
    end
`else
    assign mag_a  = srcA;
    assign mag_b  = srcB;
    assign res_hi = acc_hi;
    assign res_lo = acc_lo;
`endif

    sm_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .opd    (opd),
        .nxt_hi (step_hi),
        .nxt_lo (step_lo)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (launch) state_nxt = ST_CALC;
            ST_CALC: if (cnt == '0) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // acc_lo holds multiplier / dividend, opd holds multiplicand / divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            opd    <= '0;
            is_div <= 1'b0;
`ifdef SM_MULDIV_SIGNED_EN
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (div_zero) begin
                        hi   <= srcA;
                        lo   <= '1;
                        done <= 1'b1;
                    end else if (go && op == MD_MTHI) begin
                        hi   <= srcA;
                        done <= 1'b1;
                    end else if (go && op == MD_MTLO) begin
                        lo   <= srcA;
                        done <= 1'b1;
                    end else if (launch) begin
                        acc_hi <= '0;
                        acc_lo <= mag_a;
                        opd    <= mag_b;
                        is_div <= op[0];
                        cnt    <= CNT_W'(WIDTH - 1);
`ifdef SM_MULDIV_SIGNED_EN
                        neg_a  <= op[1] && srcA[WIDTH-1];
                        neg_b  <= op[1] && srcB[WIDTH-1];
`endif
                    end
                end
                ST_CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - CNT_W'(1);
                end
                ST_FIN: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
